// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the MEM-stage data memory responder.
// Package dmem_pkg: FSM state encoding, wait-state counter width, word width.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;   // wait-state counter, holds 0..15

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Data access port between the pipeline's MEM stage (master) and the
// timed data memory (slave). Optional feature macro: DMEM_ALIGN_CHECK_EN
// adds the err misalignment flag.
interface data_mem_responder_if;
  import dmem_pkg::*;

  logic              MemRead;
  logic              MemWrite;
  logic [WORD_W-1:0] Adress;
  logic [WORD_W-1:0] WriteData;
  logic [WORD_W-1:0] ReadData;
  logic              stall;
  logic              ack;
`ifdef DMEM_ALIGN_CHECK_EN
  logic              err;

  modport master (output MemRead, MemWrite, Adress, WriteData,
                  input  ReadData, stall, ack, err);
  modport slave  (input  MemRead, MemWrite, Adress, WriteData,
                  output ReadData, stall, ack, err);
`else
  modport master (output MemRead, MemWrite, Adress, WriteData,
                  input  ReadData, stall, ack);
  modport slave  (input  MemRead, MemWrite, Adress, WriteData,
                  output ReadData, stall, ack);
`endif

endinterface

// File: rtl/data_mem_responder_array.sv
// dmem_array: synchronous-write, registered-read word array. The read
// register is reset to zero; the storage itself is not.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic                     re,
  input  logic                     rd_clr,  // read returns 0 instead of the word
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [WORD_W-1:0]        wdata,
  output logic [WORD_W-1:0]        rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Word storage, written on the commit edge.
  // NOTE: storage has no reset branch so it maps onto RAM; only control
  // and output registers are reset.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  // Registered read port; holds until the next completed read.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rdata <= '0;
    else if (re)     rdata <= rd_clr ? '0 : mem[idx];
  end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle responder for the MEM-stage data port.
// Captures a request in IDLE, counts WAIT_CYCLES wait states, commits the
// access on the edge into ACK and pulses ack for one cycle. stall freezes
// the pipeline while the access is outstanding.
// Optional feature macro: DMEM_ALIGN_CHECK_EN (err flag, misaligned
// writes suppressed, misaligned reads return 0).
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  data_mem_responder_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               wr_q;
  logic [IDX_W-1:0]   idx_q;
  logic [WORD_W-1:0]  wdata_q;
  logic               ack_q;
`ifdef DMEM_ALIGN_CHECK_EN
  logic               mis_q;
  logic               err_q;
  logic               mis_live;
`endif

  logic               req;
  logic               in_idle;
  logic               commit;
  logic               c_wr;
  logic               c_mis;
  logic [IDX_W-1:0]   c_idx;
  logic [WORD_W-1:0]  c_wdata;
  logic               arr_we;
  logic               arr_re;
  logic [WORD_W-1:0]  rdata;
  logic               unused_addr;

  assign req     = bus.MemRead | bus.MemWrite;
  assign in_idle = (state == IDLE);

  // Address bits above the word index (and the byte offset when alignment
  // checking is off) do not select anything: out-of-range addresses wrap.
  assign unused_addr = ^{bus.Adress[WORD_W-1:IDX_W+2], bus.Adress[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
  assign mis_live = (bus.Adress[1:0] != 2'b00);
`endif

  // The access commits on the edge into ACK: straight from IDLE when there
  // are no wait states, otherwise at the end of the last WAIT cycle.
  // Gated by rst_n so an edge during reset never writes the array.
  assign commit = rst_n &
                  ((in_idle & req & (WAIT_CYCLES == 0)) |
                   ((state == WAIT) & (cnt == CNT_W'(1))));

  // Select live inputs when committing from IDLE, captured copies otherwise.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    c_wr    = wr_q;
    c_idx   = idx_q;
    c_wdata = wdata_q;
    c_mis   = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    c_mis   = mis_q;
`endif
    if (in_idle) begin
      c_wr    = bus.MemWrite;  // both requests high counts as a write
      c_idx   = bus.Adress[IDX_W+1:2];
      c_wdata = bus.WriteData;
`ifdef DMEM_ALIGN_CHECK_EN
      c_mis   = mis_live;
`endif
    end
  end

  assign arr_we = commit &  c_wr & ~c_mis;
  assign arr_re = commit & ~c_wr;

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (arr_we),
    .re     (arr_re),
    .rd_clr (c_mis),
    .idx    (c_idx),
    .wdata  (c_wdata),
    .rdata  (rdata)
  );

  // Request FSM with wait-state counter and registered ack/err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      ack_q <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      err_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req) begin
            wr_q    <= bus.MemWrite;
            idx_q   <= bus.Adress[IDX_W+1:2];
            wdata_q <= bus.WriteData;
            cnt     <= CNT_W'(WAIT_CYCLES);
`ifdef DMEM_ALIGN_CHECK_EN
            mis_q   <= mis_live;
`endif
            if (WAIT_CYCLES == 0) begin
              state <= ACK;
              ack_q <= 1'b1;
`ifdef DMEM_ALIGN_CHECK_EN
              err_q <= mis_live;
`endif
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= ACK;
            ack_q <= 1'b1;
`ifdef DMEM_ALIGN_CHECK_EN
            err_q <= mis_q;
`endif
          end
        end
        ACK:     state <= IDLE;  // a request held here is sampled next IDLE
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.stall    = rst_n & ((in_idle & req) | (state == WAIT));
  assign bus.ack      = ack_q;
  assign bus.ReadData = rdata;
`ifdef DMEM_ALIGN_CHECK_EN
  assign bus.err      = err_q;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: one instance with two wait
// states, one with none. Table-driven accesses plus hand-written sequences
// for reset, held requests and reset mid-access.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  data_mem_responder_if bus2 ();
  data_mem_responder_if bus0 ();

  data_mem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave));
  data_mem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave));

  typedef struct {
    int          sel;      // 2: WAIT_CYCLES=2 instance, 0: WAIT_CYCLES=0 instance
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic        chk;      // compare ReadData on the ack cycle
    logic [31:0] exp_rd;
    logic        exp_err;
    string       name;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int sel, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
    if (sel == 2) begin
      bus2.MemRead = rd; bus2.MemWrite = wr; bus2.Adress = a; bus2.WriteData = d;
    end else begin
      bus0.MemRead = rd; bus0.MemWrite = wr; bus0.Adress = a; bus0.WriteData = d;
    end
  endtask

  task automatic get_out(input int sel, output logic s, output logic a,
                         output logic e, output logic [31:0] r);
    e = 1'b0;
    if (sel == 2) begin
      s = bus2.stall; a = bus2.ack; r = bus2.ReadData;
`ifdef DMEM_ALIGN_CHECK_EN
      e = bus2.err;
`endif
    end else begin
      s = bus0.stall; a = bus0.ack; r = bus0.ReadData;
`ifdef DMEM_ALIGN_CHECK_EN
      e = bus0.err;
`endif
    end
  endtask

  // One complete access starting in an IDLE cycle (called at posedge+1).
  // Checks stall for WAIT_CYCLES+1 cycles, then the ack cycle.
  task automatic access(input vec_t v);
    logic s, a, e;
    logic [31:0] r;
    int wc;
    wc = (v.sel == 2) ? 2 : 0;
    set_req(v.sel, v.rd, v.wr, v.addr, v.data);
    for (int c = 0; c <= wc; c++) begin
      @(negedge clk);
      get_out(v.sel, s, a, e, r);
      check({v.name, "_stall"}, {31'd0, s}, 32'd1);
      check({v.name, "_noack"}, {31'd0, a}, 32'd0);
      @(posedge clk); #1;
    end
    set_req(v.sel, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    get_out(v.sel, s, a, e, r);
    check({v.name, "_ack"}, {31'd0, a}, 32'd1);
    check({v.name, "_ack_nostall"}, {31'd0, s}, 32'd0);
`ifdef DMEM_ALIGN_CHECK_EN
    check({v.name, "_err"}, {31'd0, e}, {31'd0, v.exp_err});
`endif
    if (v.chk) check({v.name, "_rdata"}, r, v.exp_rd);
    @(posedge clk); #1;
  endtask

  vec_t vecs[$];
  vec_t al_vecs[$];

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic s, a, e;
    logic [31:0] r;

    // sel  rd   wr   addr   data         chk  exp_rd       err  name
    vecs.push_back('{2, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1, 32'h0,        1'b0, "wr_10"});
    vecs.push_back('{2, 1'b1, 1'b0, 32'h10, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, "rd_10"});
    vecs.push_back('{2, 1'b0, 1'b1, 32'h100,32'hA5,       1'b1, 32'hDEADBEEF, 1'b0, "wr_100_hold"});
    vecs.push_back('{2, 1'b1, 1'b0, 32'h0,  32'h0,        1'b1, 32'hA5,       1'b0, "rd_0_wrap"});
    vecs.push_back('{2, 1'b0, 1'b1, 32'h8,  32'h77,       1'b1, 32'hA5,       1'b0, "wr_8"});
    vecs.push_back('{2, 1'b1, 1'b1, 32'h14, 32'h12345678, 1'b1, 32'hA5,       1'b0, "rdwr_14"});
    vecs.push_back('{2, 1'b1, 1'b0, 32'h14, 32'h0,        1'b1, 32'h12345678, 1'b0, "rd_14"});
    vecs.push_back('{0, 1'b0, 1'b1, 32'h0,  32'h11,       1'b1, 32'h0,        1'b0, "w0_wr_0"});
    vecs.push_back('{0, 1'b0, 1'b1, 32'h4,  32'h22,       1'b1, 32'h0,        1'b0, "w0_wr_4"});
    vecs.push_back('{0, 1'b1, 1'b0, 32'h0,  32'h0,        1'b1, 32'h11,       1'b0, "w0_rd_0"});
    vecs.push_back('{0, 1'b1, 1'b0, 32'h4,  32'h0,        1'b1, 32'h22,       1'b0, "w0_rd_4"});

    al_vecs.push_back('{2, 1'b0, 1'b1, 32'h4, 32'h44, 1'b0, 32'h0,  1'b0, "al_wr_4"});
    al_vecs.push_back('{2, 1'b0, 1'b1, 32'h6, 32'h99, 1'b0, 32'h0,  1'b1, "al_wr_6"});
    al_vecs.push_back('{2, 1'b1, 1'b0, 32'h4, 32'h0,  1'b1, 32'h44, 1'b0, "al_rd_4"});
    al_vecs.push_back('{2, 1'b1, 1'b0, 32'h6, 32'h0,  1'b1, 32'h0,  1'b1, "al_rd_6"});

    // Reset with a request present: stall forced low, outputs at reset values.
    rst_n = 1'b0;
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_req(2, 1'b1, 1'b0, 32'h10, 32'd0);
    @(negedge clk);
    get_out(2, s, a, e, r);
    check("rst_stall", {31'd0, s}, 32'd0);
    check("rst_ack", {31'd0, a}, 32'd0);
    check("rst_rdata", r, 32'd0);
    set_req(2, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      get_out(2, s, a, e, r);
      check("idle_stall", {31'd0, s}, 32'd0);
      check("idle_ack", {31'd0, a}, 32'd0);
      check("idle_rdata", r, 32'd0);
      @(posedge clk); #1;
    end

    for (int i = 0; i < vecs.size(); i++) access(vecs[i]);

    // Read held through ACK on the zero-wait instance: ack every second cycle.
    set_req(0, 1'b1, 1'b0, 32'h0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      get_out(0, s, a, e, r);
      check("held_stall", {31'd0, s}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("held_ack", {31'd0, a}, (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i % 2 == 1) check("held_rdata", r, 32'h11);
      @(posedge clk); #1;
    end
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Reset during the WAIT of a write of 0x55 to 0x8: aborted, no ack.
    set_req(2, 1'b0, 1'b1, 32'h8, 32'h55);
    @(negedge clk);
    get_out(2, s, a, e, r);
    check("abort_stall0", {31'd0, s}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    get_out(2, s, a, e, r);
    check("abort_stall1", {31'd0, s}, 32'd1);
    rst_n = 1'b0;
    set_req(2, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    get_out(2, s, a, e, r);
    check("abort_rst_stall", {31'd0, s}, 32'd0);
    check("abort_rst_rdata", r, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      get_out(2, s, a, e, r);
      check("abort_noack", {31'd0, a}, 32'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    get_out(2, s, a, e, r);
    check("abort_post_ack", {31'd0, a}, 32'd0);
    @(posedge clk); #1;
    access('{2, 1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 32'h77, 1'b0, "abort_rd_8"});

`ifdef DMEM_ALIGN_CHECK_EN
    for (int i = 0; i < al_vecs.size(); i++) access(al_vecs[i]);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
